// File: rtl/spi_bank_arbiter.sv
// Purpose: round-robin arbiter + burst sequencer sharing the SPI register bank port among NREQ requesters.
// Latency: Req high in IDLE -> registered Grant next cycle, first Ack that same cycle; len+2 cycles per burst.
// Backpressure: requester holds Req until final Ack; dropping Req mid-burst aborts with no access that cycle.
//
// Ports:
//   Clk, Reset                         clock, synchronous active-high reset
//   Req/Req_WE/Req_Addr/Req_Len/Req_WData   per-requester burst request (4/4/32 bits per requester slice)
//   Grant, Busy                        registered owner one-hot / transfer-in-progress
//   Ack, Last, Rdata                   per-word handshake, final-word flag, read data
//   Data_WE/Data_Addr/Data_Write/Data_Read   shared bank port (Data_Read combinational from Data_Addr)
module spi_bank_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ-1:0]      Req_WE,
  input  logic [4*NREQ-1:0]    Req_Addr,
  input  logic [4*NREQ-1:0]    Req_Len,
  input  logic [32*NREQ-1:0]   Req_WData,
  output logic [NREQ-1:0]      Grant,
  output logic [NREQ-1:0]      Ack,
  output logic                 Last,
  output logic [31:0]          Rdata,
  output logic                 Busy,
  output logic                 Data_WE,
  output logic [31:0]          Data_Addr,
  output logic [31:0]          Data_Write,
  input  logic [31:0]          Data_Read
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win;
  logic [PW-1:0] next_ptr;
  logic          found;
  logic          xfer_we;
  logic [3:0]    start_q;
  logic [3:0]    len_q;
  logic [3:0]    count_q;
  logic [3:0]    idx;
  logic          owner_req;
  logic          active;
  logic          final_word;

  // 4-bit sum wraps the word index 15 -> 0 inside a burst
  assign idx        = start_q + count_q;
  assign owner_req  = Req[owner];
  assign active     = (state == XFER) && owner_req;
  assign final_word = (count_q == len_q);
  assign Busy       = (state == XFER);
  assign next_ptr   = (int'(owner) == NREQ - 1) ? '0 : owner + PW'(1);

  // Rotating priority scan starting at ptr; the just-served requester sits last
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && Req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Bank access is combinational so a word is accessed in the same cycle it is acked,
  // including the cycle in which Reset is asserted.
  always_comb begin
    Ack        = '0;
    Last       = 1'b0;
    Rdata      = '0;
    Data_WE    = 1'b0;
    Data_Addr  = '0;
    Data_Write = '0;
    if (active) begin
      Ack[owner] = 1'b1;
      Last       = final_word;
      Rdata      = Data_Read;
      Data_WE    = xfer_we;
      if (xfer_we) begin
        // MISO bank decodes a word index, MOSI bank decodes a byte address
        Data_Addr  = {28'b0, idx};
        Data_Write = Req_WData[32*int'(owner) +: 32];
      end else begin
        Data_Addr  = {26'b0, idx, 2'b00};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      Grant   <= '0;
      ptr     <= '0;
      owner   <= '0;
      xfer_we <= 1'b0;
      start_q <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        Grant   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
        owner   <= win;
        xfer_we <= Req_WE[win];
        start_q <= Req_Addr[4*int'(win) +: 4];
        len_q   <= Req_Len[4*int'(win) +: 4];
        count_q <= '0;
        state   <= XFER;
      end
    end else begin
      // Completion and abort both return to IDLE and rotate priority past the owner
      if (!owner_req || final_word) begin
        state <= IDLE;
        Grant <= '0;
        ptr   <= next_ptr;
      end else begin
        count_q <= count_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_bank_arbiter.sv
module tb_spi_bank_arbiter;
  localparam int NREQ = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req, req_we;
  logic [15:0]   req_addr, req_len;
  logic [127:0]  req_wdata;
  logic [3:0]    grant, ack;
  logic          last, busy, data_we;
  logic [31:0]   rdata, data_addr, data_write, data_read;

  logic [31:0]   mosi [16];
  logic [31:0]   miso [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_bank_arbiter #(.NREQ(NREQ)) dut (
    .Clk(clk), .Reset(reset), .Req(req), .Req_WE(req_we), .Req_Addr(req_addr),
    .Req_Len(req_len), .Req_WData(req_wdata), .Grant(grant), .Ack(ack), .Last(last),
    .Rdata(rdata), .Busy(busy), .Data_WE(data_we), .Data_Addr(data_addr),
    .Data_Write(data_write), .Data_Read(data_read)
  );

  // Bank model: MOSI read combinationally by byte address, MISO written by word index
  assign data_read = mosi[data_addr[5:2]];
  always @(posedge clk) if (data_we) miso[data_addr[3:0]] <= data_write;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge; outputs are sampled 1ns later, well away from posedge
  task automatic apply(input bit rst, input logic [3:0] rq, input logic [3:0] we,
                       input logic [15:0] ad, input logic [15:0] ln, input logic [127:0] wd);
    @(negedge clk);
    reset = rst; req = rq; req_we = we; req_addr = ad; req_len = ln; req_wdata = wd;
    #1;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit          rst;
    logic [3:0]  rq, we;
    logic [15:0] ad, ln;
    logic [31:0] wd;
    logic [3:0]  e_grant, e_ack;
    bit          e_last, e_we, e_busy;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [3:0] rq, logic [3:0] we, logic [15:0] ad,
                              logic [15:0] ln, logic [31:0] wd, logic [3:0] eg, logic [3:0] ea,
                              bit el, bit ewe, logic [31:0] eaddr, bit eb);
    vec_t v;
    v.rst = rst; v.rq = rq; v.we = we; v.ad = ad; v.ln = ln; v.wd = wd;
    v.e_grant = eg; v.e_ack = ea; v.e_last = el; v.e_we = ewe; v.e_addr = eaddr; v.e_busy = eb;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  // A burst is a queue of word indices still to be transferred; idle is owner < 0.
  int m_owner = -1;
  int m_ptr   = 0;
  bit m_we    = 1'b0;
  int m_q[$];

  task automatic model_step(input bit rst);
    bit got;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_q.delete();
    end else if (m_owner < 0) begin
      got = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!got && req[i]) begin
          got = 1'b1;
          m_owner = i;
          m_we = req_we[i];
          m_q.delete();
          for (int j = 0; j <= int'(req_len[4*i +: 4]); j++)
            m_q.push_back((int'(req_addr[4*i +: 4]) + j) % 16);
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_q.delete();
    end else begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
      end
    end
  endtask

  task automatic model_check();
    bit          act;
    logic [3:0]  e_grant, e_ack;
    logic [31:0] e_addr, e_wdata;
    act     = (m_owner >= 0) && req[m_owner];
    e_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e_ack   = act ? (4'b0001 << m_owner) : 4'b0000;
    e_addr  = act ? (m_we ? m_q[0] : m_q[0] * 4) : 0;
    e_wdata = (act && m_we) ? req_wdata[32*m_owner +: 32] : 32'h0;
    chk("rnd_grant", grant, e_grant);
    chk("rnd_busy", busy, m_owner >= 0);
    chk("rnd_ack", ack, e_ack);
    chk("rnd_last", last, act && m_q.size() == 1);
    chk("rnd_data_we", data_we, act && m_we);
    chk("rnd_data_addr", data_addr, e_addr);
    chk("rnd_data_write", data_write, e_wdata);
    if (act && !m_we) chk("rnd_rdata", rdata, mosi[m_q[0]]);
  endtask

  initial begin
    logic [3:0]   r_req;
    logic [15:0]  r_len;
    logic [31:0]  exp_addr2 [4];
    bit           r_rst;

    for (int i = 0; i < 16; i++) mosi[i] = $urandom;
    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;

    // Write burst of 3 words by requester 1, then round-robin of single-word reads
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 32'h0,  4'b0000, 4'b0000, 0, 0, 0,  0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 16'h3333, 16'h2222, 32'hA0, 4'b0000, 4'b0000, 0, 0, 0,  0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 16'h3333, 16'h2222, 32'hA0, 4'b0010, 4'b0010, 0, 1, 3,  1));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 16'h3333, 16'h2222, 32'hA1, 4'b0010, 4'b0010, 0, 1, 4,  1));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 16'h3333, 16'h2222, 32'hA2, 4'b0010, 4'b0010, 1, 1, 5,  1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 16'h3333, 16'h2222, 32'h0,  4'b0000, 4'b0000, 0, 0, 0,  0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 32'h0,  4'b0000, 4'b0000, 0, 0, 0,  0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h4321, 16'h0000, 32'h0,  4'b0000, 4'b0000, 0, 0, 0,  0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h4321, 16'h0000, 32'h0,  4'b0001, 4'b0001, 1, 0, 4,  1));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h4321, 16'h0000, 32'h0,  4'b0000, 4'b0000, 0, 0, 0,  0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h4321, 16'h0000, 32'h0,  4'b0010, 4'b0010, 1, 0, 8,  1));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h4321, 16'h0000, 32'h0,  4'b0000, 4'b0000, 0, 0, 0,  0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h4321, 16'h0000, 32'h0,  4'b0100, 4'b0100, 1, 0, 12, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h4321, 16'h0000, 32'h0,  4'b0000, 4'b0000, 0, 0, 0,  0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h4321, 16'h0000, 32'h0,  4'b1000, 4'b1000, 1, 0, 16, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h4321, 16'h0000, 32'h0,  4'b0000, 4'b0000, 0, 0, 0,  0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h4321, 16'h0000, 32'h0,  4'b0001, 4'b0001, 1, 0, 4,  1));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 32'h0,  4'b0000, 4'b0000, 0, 0, 0,  0));

    apply(1, '0, '0, '0, '0, '0);
    for (int n = 0; n < tbl.size(); n++) begin
      apply(tbl[n].rst, tbl[n].rq, tbl[n].we, tbl[n].ad, tbl[n].ln, {4{tbl[n].wd}});
      chk($sformatf("tbl%0d_grant", n), grant, tbl[n].e_grant);
      chk($sformatf("tbl%0d_ack", n), ack, tbl[n].e_ack);
      chk($sformatf("tbl%0d_last", n), last, tbl[n].e_last);
      chk($sformatf("tbl%0d_data_we", n), data_we, tbl[n].e_we);
      chk($sformatf("tbl%0d_data_addr", n), data_addr, tbl[n].e_addr);
      chk($sformatf("tbl%0d_busy", n), busy, tbl[n].e_busy);
      if (n == 4) chk("tbl_wdata_word2", data_write, 32'hA2);
    end
    chk("miso3", miso[3], 32'hA0);
    chk("miso4", miso[4], 32'hA1);
    chk("miso5", miso[5], 32'hA2);

    // Read burst from 14 wrapping past 15
    exp_addr2[0] = 32'h38; exp_addr2[1] = 32'h3C; exp_addr2[2] = 32'h00; exp_addr2[3] = 32'h04;
    apply(1, '0, '0, '0, '0, '0);
    apply(0, 4'b0100, 4'b0000, {4{4'hE}}, {4{4'h3}}, '0);
    for (int j = 0; j < 4; j++) begin
      apply(0, 4'b0100, 4'b0000, {4{4'hE}}, {4{4'h3}}, '0);
      chk($sformatf("wrap_addr%0d", j), data_addr, exp_addr2[j]);
      chk($sformatf("wrap_rdata%0d", j), rdata, mosi[(14 + j) % 16]);
      chk($sformatf("wrap_last%0d", j), last, j == 3);
    end
    apply(0, 4'b0000, '0, '0, '0, '0);
    chk("wrap_idle_busy", busy, 1'b0);

    // Abort after 2 of 5 words; priority must then rotate to requester 3
    apply(1, '0, '0, '0, '0, '0);
    apply(0, 4'b0100, 4'b0100, 16'h0000, {4{4'h4}}, {4{32'h55}});
    apply(0, 4'b0100, 4'b0100, 16'h0000, {4{4'h4}}, {4{32'h55}});
    chk("abort_ack1", ack, 4'b0100);
    apply(0, 4'b0100, 4'b0100, 16'h0000, {4{4'h4}}, {4{32'h56}});
    chk("abort_ack2", ack, 4'b0100);
    apply(0, 4'b0000, 4'b0100, 16'h0000, {4{4'h4}}, {4{32'h57}});
    chk("abort_drop_ack", ack, 4'b0000);
    chk("abort_drop_we", data_we, 1'b0);
    apply(0, 4'b1111, 4'b0000, 16'h0000, 16'h0000, '0);
    chk("abort_idle_busy", busy, 1'b0);
    chk("abort_idle_grant", grant, 4'b0000);
    apply(0, 4'b1111, 4'b0000, 16'h0000, 16'h0000, '0);
    chk("abort_next_grant", grant, 4'b1000);
    apply(0, 4'b0000, '0, '0, '0, '0);
    apply(0, 4'b0000, '0, '0, '0, '0);

    // Reset during word 4 of a 16-word write; restart from the start address
    apply(1, '0, '0, '0, '0, '0);
    apply(0, 4'b0001, 4'b0001, {4{4'h7}}, {4{4'hF}}, '0);
    for (int j = 0; j < 3; j++) begin
      apply(0, 4'b0001, 4'b0001, {4{4'h7}}, {4{4'hF}}, {4{32'h100 + 32'(j)}});
      chk($sformatf("rst_addr%0d", j), data_addr, 32'(7 + j));
    end
    apply(1, 4'b0001, 4'b0001, {4{4'h7}}, {4{4'hF}}, {4{32'h103}});
    chk("rst_word4_we", data_we, 1'b1);
    chk("rst_word4_addr", data_addr, 32'd10);
    apply(0, 4'b0001, 4'b0001, {4{4'h7}}, {4{4'hF}}, '0);
    chk("rst_after_grant", grant, 4'b0000);
    chk("rst_after_busy", busy, 1'b0);
    apply(0, 4'b0001, 4'b0001, {4{4'h7}}, {4{4'hF}}, '0);
    chk("rst_restart_grant", grant, 4'b0001);
    chk("rst_restart_addr", data_addr, 32'd7);
    apply(0, 4'b0000, '0, '0, '0, '0);
    apply(0, 4'b0000, '0, '0, '0, '0);

    // Request rising during another requester's Last cycle
    apply(1, '0, '0, '0, '0, '0);
    apply(0, 4'b1000, 4'b0000, {4{4'h5}}, 16'h0000, '0);
    apply(0, 4'b1001, 4'b0000, {4{4'h5}}, 16'h0000, '0);
    chk("late_ack3", ack, 4'b1000);
    chk("late_last3", last, 1'b1);
    apply(0, 4'b0001, 4'b0000, {4{4'h5}}, 16'h0000, '0);
    chk("late_idle_busy", busy, 1'b0);
    apply(0, 4'b0001, 4'b0000, {4{4'h5}}, 16'h0000, '0);
    chk("late_grant0", grant, 4'b0001);
    chk("late_ack0", ack, 4'b0001);
    apply(0, 4'b0000, '0, '0, '0, '0);

    // Randomized traffic against the reference model
    r_req = '0;
    for (int c = 0; c < 2000; c++) begin
      r_rst = (c == 0) || ($urandom_range(0, 127) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) r_req[i] = ~r_req[i];
        r_len[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 2));
      end
      apply(r_rst, r_req, 4'($urandom), 16'($urandom), r_len,
            {$urandom, $urandom, $urandom, $urandom});
      model_check();
      model_step(r_rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
